// File: rtl/ingress_frame_writer.sv
// ingress_frame_writer
//
// Stages one ingress frame (descriptor word followed by payload words) in a
// local buffer while accumulating a CRC over the payload. Once the last word
// arrives, it writes a header word and then the buffered payload into the
// egress queue selected by the descriptor.
//
// Ports
//   clk, rst_n        clock; synchronous reset, active HIGH despite the name
//   wr_data/wr_vld    ingress word and its valid flag
//   wr_sop            marks the descriptor word (priority + destination)
//   wr_eop            marks the last payload word
//   in_ready          block accepts an ingress word this cycle
//   q_full            per-queue full flags
//   q_wr_en/sel/data  queue write strobe, target queue, queue word
//   busy              a frame is being received, staged, drained or dropped
//   drop              one-cycle pulse per dropped frame
//   frame_drop_cnt    saturating count of drop pulses; present only when the
//                     FRAME_DROP_CNT_EN macro is defined
//
// Handshake: an ingress word transfers on a rising edge where
// wr_vld & in_ready are both 1; wr_vld=0 words are ignored. A queue word is
// written on a rising edge where q_wr_en=1; q_wr_en is never raised while
// q_full[q_wr_sel]=1.
//
// CRC: reflected CRC-32 polynomial 0xEDB88320, seed all-ones, no final xor,
// each word consumed LSB first.
//
// Header word, LSB first: priority, CRC, word count, zero pad.

module ingress_frame_writer #(
    parameter int DATA_WIDTH       = 64,
    parameter int PORT_NUB_TOTAL   = 16,
    parameter int PRI_NUM_TOTAL    = 8,
    parameter int CRC32_LENGTH     = 32,
    parameter int DATABUF_HIGH_NUM = 8,
    parameter int BUF_DEPTH        = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_vld,
    input  logic                                 wr_sop,
    input  logic                                 wr_eop,
    output logic                                 in_ready,
    input  logic [PORT_NUB_TOTAL-1:0]            q_full,
    output logic                                 q_wr_en,
    output logic [$clog2(PORT_NUB_TOTAL)-1:0]    q_wr_sel,
    output logic [DATA_WIDTH-1:0]                q_wr_data,
    output logic                                 busy,
    output logic                                 drop
`ifdef FRAME_DROP_CNT_EN
    ,
    output logic [15:0]                          frame_drop_cnt
`endif
);

    localparam int PORT_WIDTH  = $clog2(PORT_NUB_TOTAL);
    localparam int PRI_NUM_BIT = $clog2(PRI_NUM_TOTAL);
    localparam int ADDR_W      = $clog2(BUF_DEPTH);
    localparam int CNT_W       = DATABUF_HIGH_NUM;
    localparam int CNT_MAX     = (2 ** DATABUF_HIGH_NUM) - 1;
    // A frame may hold at most this many payload words: limited by the
    // buffer and by what the header count field can express.
    localparam int LIMIT       = (BUF_DEPTH < CNT_MAX) ? BUF_DEPTH : CNT_MAX;

    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CNT_LIMIT = CNT_W'(LIMIT);
    localparam logic [CRC32_LENGTH-1:0] CRC_POLY  = CRC32_LENGTH'(32'hEDB88320);
    localparam logic [CRC32_LENGTH-1:0] CRC_SEED  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_HDR,
        S_DRAIN,
        S_DROP
    } state_t;

    function automatic logic [CRC32_LENGTH-1:0] crc_next(
        input logic [CRC32_LENGTH-1:0] c,
        input logic [DATA_WIDTH-1:0]   d
    );
        logic [CRC32_LENGTH-1:0] r;
        r = c;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          rd_idx_q, rd_idx_d;
    logic [CRC32_LENGTH-1:0]   crc_q, crc_d;
    logic [PRI_NUM_BIT-1:0]    pri_q, pri_d;
    logic [PORT_WIDTH-1:0]     dest_q, dest_d;
    logic                      drop_q, drop_d;
    logic [DATA_WIDTH-1:0]     mem_q [BUF_DEPTH];

    logic                      accept;
    logic                      start_new;
    logic                      mem_we;
    logic                      dest_full;
    logic [DATA_WIDTH-1:0]     hdr_word;

    // Reset overrides the state-based ready so no word is taken while held.
    assign in_ready  = !rst_n && (state_q == S_IDLE || state_q == S_RECV || state_q == S_DROP);
    assign accept    = wr_vld && in_ready;
    assign dest_full = q_full[dest_q];
    assign busy      = (state_q != S_IDLE);
    assign drop      = drop_q;

    always_comb begin
        hdr_word = '0;
        hdr_word[PRI_NUM_BIT-1:0]                            = pri_q;
        hdr_word[PRI_NUM_BIT +: CRC32_LENGTH]                = crc_q;
        hdr_word[PRI_NUM_BIT+CRC32_LENGTH +: DATABUF_HIGH_NUM] = count_q;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        crc_d     = crc_q;
        pri_d     = pri_q;
        dest_d    = dest_q;
        drop_d    = 1'b0;
        start_new = 1'b0;
        mem_we    = 1'b0;
        q_wr_en   = 1'b0;
        q_wr_sel  = '0;
        q_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (accept && wr_sop) begin
                    // A descriptor that is also the last word has no payload.
                    if (wr_eop) drop_d = 1'b1;
                    else begin
                        start_new = 1'b1;
                        state_d   = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    if (wr_sop) begin
                        // New descriptor abandons the frame in progress.
                        drop_d = 1'b1;
                        if (wr_eop) state_d = S_IDLE;
                        else        start_new = 1'b1;
                    end else if (count_q == CNT_LIMIT) begin
                        if (wr_eop) begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_ONE;
                        crc_d   = crc_next(crc_q, wr_data);
                        if (wr_eop) state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                q_wr_sel  = dest_q;
                q_wr_data = hdr_word;
                if (!dest_full && !rst_n) begin
                    q_wr_en  = 1'b1;
                    rd_idx_d = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                q_wr_sel  = dest_q;
                q_wr_data = mem_q[rd_idx_q[ADDR_W-1:0]];
                if (!dest_full && !rst_n) begin
                    q_wr_en = 1'b1;
                    if (rd_idx_q == count_q - CNT_ONE) state_d = S_IDLE;
                    else                               rd_idx_d = rd_idx_q + CNT_ONE;
                end
            end
            S_DROP: begin
                if (accept) begin
                    if (wr_sop) begin
                        drop_d = 1'b1;
                        if (wr_eop) state_d = S_IDLE;
                        else begin
                            start_new = 1'b1;
                            state_d   = S_RECV;
                        end
                    end else if (wr_eop) begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_new) begin
            pri_d   = wr_data[PRI_NUM_BIT-1:0];
            dest_d  = wr_data[PRI_NUM_BIT +: PORT_WIDTH];
            count_d = '0;
            crc_d   = CRC_SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_idx_q <= '0;
            crc_q    <= '0;
            pri_q    <= '0;
            dest_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            crc_q    <= crc_d;
            pri_q    <= pri_d;
            dest_q   <= dest_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage needs no reset: it is only read below a valid count.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[count_q[ADDR_W-1:0]] <= wr_data;
    end

`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign frame_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ingress_frame_writer.sv
// Testbench for ingress_frame_writer: random frames driven through tasks,
// expected queue words (header + payload) pushed into a scoreboard queue at
// issue time, and a negedge monitor that pops and compares every queue write.
// The CRC reference is a byte-table CRC-32 (reflected 0xEDB88320, seed
// all-ones, no final xor, bytes of each word taken LSB first).

module tb_ingress_frame_writer;

    localparam int LIMIT = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] wr_data = '0;
    logic        wr_vld  = 1'b0;
    logic        wr_sop  = 1'b0;
    logic        wr_eop  = 1'b0;
    logic        in_ready;
    logic [15:0] q_full  = '0;
    logic        q_wr_en;
    logic [3:0]  q_wr_sel;
    logic [63:0] q_wr_data;
    logic        busy;
    logic        drop;
`ifdef FRAME_DROP_CNT_EN
    logic [15:0] frame_drop_cnt;
`endif

    ingress_frame_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_vld    (wr_vld),
        .wr_sop    (wr_sop),
        .wr_eop    (wr_eop),
        .in_ready  (in_ready),
        .q_full    (q_full),
        .q_wr_en   (q_wr_en),
        .q_wr_sel  (q_wr_sel),
        .q_wr_data (q_wr_data),
        .busy      (busy),
        .drop      (drop)
`ifdef FRAME_DROP_CNT_EN
        ,
        .frame_drop_cnt (frame_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q [$];
    logic [3:0]  exp_sel_q [$];
    logic [63:0] pl [$];
    logic [31:0] crc_tbl [256];
    int          tests = 0;
    int          fails = 0;
    int          exp_drops = 0;
    int          drop_seen = 0;
    int          wr_seen = 0;
    bit          bp_en = 1'b0;
    bit          prev_abort = 1'b0;
    logic [15:0] force_full = '0;

    // Backpressure source: random per-queue full flags or a forced pattern.
    always @(posedge clk) begin
        #1;
        q_full = bp_en ? (16'($urandom) & 16'($urandom)) : force_full;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        logic [3:0]  s;
        if (q_wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: sel=%0d data=%h required no write", q_wr_sel, q_wr_data);
            end else begin
                e = exp_q.pop_front();
                s = exp_sel_q.pop_front();
                check("queue_word", q_wr_data, e);
                check("queue_sel", 64'(q_wr_sel), 64'(s));
                wr_seen++;
            end
            check("write_while_full", 64'(q_full[q_wr_sel]), 64'(0));
        end else if (in_ready) begin
            check("idle_data_zero", q_wr_data, 64'(0));
        end
        if (drop) drop_seen++;
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] exp_header(input int n, input int pri);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        foreach (pl[i]) begin
            for (int k = 0; k < 8; k++) begin
                b = pl[i][8*k +: 8];
                c = (c >> 8) ^ crc_tbl[c[7:0] ^ b];
            end
        end
        return (64'(n) << 35) | (64'(c) << 3) | 64'(pri & 7);
    endfunction

    // ---------------- driver ----------------
    task automatic send_word(input logic [63:0] d, input bit sop, input bit eop);
        int n;
        n = 0;
        wr_data = d;
        wr_sop  = sop;
        wr_eop  = eop;
        wr_vld  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        wr_vld  = 1'b0;
        wr_sop  = 1'($urandom);
        wr_eop  = 1'($urandom);
        wr_data = {$urandom, $urandom};
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back({$urandom, $urandom});
    endtask

    // Sends descriptor + pl; abort=1 leaves the frame without eop so the
    // next descriptor kills it.
    task automatic send_frame(input int dest, input int pri, input bit abort);
        logic [63:0] desc;
        int n;
        n = pl.size();
        if (!prev_abort && $urandom_range(0, 7) == 0)
            send_word({$urandom, $urandom}, 1'b0, 1'($urandom));
        if (!abort && n > 0 && n <= LIMIT) begin
            exp_q.push_back(exp_header(n, pri));
            exp_sel_q.push_back(4'(dest));
            foreach (pl[i]) begin
                exp_q.push_back(pl[i]);
                exp_sel_q.push_back(4'(dest));
            end
        end else begin
            exp_drops++;
        end
        desc = {$urandom, $urandom};
        desc[6:0] = {4'(dest), 3'(pri)};
        send_word(desc, 1'b1, (n == 0) && !abort);
        for (int i = 0; i < n; i++) begin
            gap();
            send_word(pl[i], 1'b0, !abort && (i == n - 1));
        end
        prev_abort = abort;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d required idle", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int drops_before;
        int n;
        for (int b = 0; b < 256; b++) begin
            logic [31:0] c;
            c = 32'(b);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[b] = c;
        end

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_wr_en", 64'(q_wr_en), 64'(0));
        check("reset_drop", 64'(drop), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Basic frame: pri 5, dest 3, three words
        pl.delete();
        pl.push_back(64'h11);
        pl.push_back(64'h22);
        pl.push_back(64'h33);
        send_frame(3, 5, 1'b0);
        wait_idle();

        // Same frame with queue 3 full for 4 cycles from the first drain word
        send_frame(3, 5, 1'b0);
        @(posedge clk);
        #1;
        force_full = 16'h0008;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        force_full = '0;
        wait_idle();

        // Zero-payload descriptor
        pl.delete();
        send_frame(2, 1, 1'b0);
        @(negedge clk);
        check("zero_frame_in_ready", 64'(in_ready), 64'(1));
        check("zero_frame_drop", 64'(drop), 64'(1));
        @(posedge clk);
        #1;

        // Buffer boundary: 64 fits, 65 and 70 overflow
        rand_payload(64);
        send_frame(9, 2, 1'b0);
        rand_payload(65);
        send_frame(4, 6, 1'b0);
        rand_payload(70);
        send_frame(5, 7, 1'b0);
        wait_idle();

        // Frame A aborted by frame B's descriptor
        rand_payload(2);
        send_frame(1, 3, 1'b1);
        rand_payload(1);
        send_frame(7, 4, 1'b0);
        wait_idle();

        // Random traffic under random backpressure
        bp_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                pl.delete();
                send_frame($urandom_range(0, 15), $urandom_range(0, 7), 1'b0);
            end else if (kind == 1) begin
                rand_payload($urandom_range(0, 4));
                send_frame($urandom_range(0, 15), $urandom_range(0, 7), 1'b1);
            end else begin
                rand_payload($urandom_range(1, 12));
                send_frame($urandom_range(0, 15), $urandom_range(0, 7), 1'b0);
            end
        end
        rand_payload(3);
        send_frame(6, 0, 1'b0);
        wait_idle();
        bp_en = 1'b0;

        // Reset after header + 2 of 5 payload words drained
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        drops_before = drop_seen;
        base = wr_seen;
        rand_payload(5);
        send_frame(2, 4, 1'b0);
        n = 0;
        while (wr_seen < base + 3 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (wr_seen < base + 3) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: writes=%0d required %0d", wr_seen - base, 3);
        end
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_sel_q.delete();
        @(negedge clk);
        check("midreset_in_ready", 64'(in_ready), 64'(0));
        check("midreset_wr_en", 64'(q_wr_en), 64'(0));
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_drop", 64'(drop), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_release_ready", 64'(in_ready), 64'(1));
        repeat (10) @(negedge clk);
        check("midreset_no_drop", 64'(drop_seen), 64'(drops_before));
        check("midreset_writes", 64'(wr_seen - base), 64'(3));

        // Final accounting
        check("drop_total", 64'(drop_seen), 64'(exp_drops));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
`ifdef FRAME_DROP_CNT_EN
        check("frame_drop_cnt", 64'(frame_drop_cnt), 64'(0));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ingress_frame_writer.md
INGRESS_FRAME_WRITER -- requirements
Module: ingress_frame_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning ingress and queue word width.
REQ-002 SHALL have parameter PORT_NUB_TOTAL, default 16, meaning number of egress queues; PORT_WIDTH = clog2(PORT_NUB_TOTAL).
REQ-003 SHALL have parameter PRI_NUM_TOTAL, default 8, meaning priority levels; PRI_NUM_BIT = clog2(PRI_NUM_TOTAL).
REQ-004 SHALL have parameter CRC32_LENGTH, default 32, meaning CRC field width.
REQ-005 SHALL have parameter DATABUF_HIGH_NUM, default 8, meaning frame-word-count field width.
REQ-006 SHALL have parameter BUF_DEPTH, default 64, meaning staging buffer depth in payload words.
REQ-007 SHALL have ports: clk in 1, clock; rst_n in 1, reset (one clock; reset is synchronous and active-high, asserted when rst_n=1).
REQ-008 SHALL have ports: wr_data in DATA_WIDTH, ingress word; wr_vld in 1, word valid; wr_sop in 1, descriptor word; wr_eop in 1, last payload word; in_ready out 1, block accepts words.
REQ-009 SHALL have ports: q_full in PORT_NUB_TOTAL, per-queue full; q_wr_en out 1, queue write strobe; q_wr_sel out PORT_WIDTH, target queue; q_wr_data out DATA_WIDTH, queue word.
REQ-010 SHALL have ports: busy out 1, frame staged or draining; drop out 1, one-cycle pulse per dropped frame.

Function
REQ-011 Descriptor word (wr_vld & wr_sop): priority = wr_data[PRI_NUM_BIT-1:0], destination = wr_data[PRI_NUM_BIT+PORT_WIDTH-1:PRI_NUM_BIT]; no payload in this word.
REQ-012 A word transfers only when wr_vld & in_ready; words with wr_vld=0 ignored; in_ready=1 only in IDLE, RECV, DROP.
REQ-013 States: IDLE, RECV, HDR, DRAIN, DROP; reset state IDLE.
REQ-014 IDLE: descriptor -> RECV, clear word count, reset CRC; non-sop words ignored.
REQ-015 RECV: each payload word written to buffer, count+1, CRC updated (crc16_32bit over the word, same polynomial/seed egress checks); wr_eop -> HDR.
REQ-016 Header word = {zero pad, count[DATABUF_HIGH_NUM-1:0], crc[CRC32_LENGTH-1:0], priority[PRI_NUM_BIT-1:0]}, LSB-first in that order.
REQ-017 HDR: first cycle with q_full[dest]=0, q_wr_en=1 with header, -> DRAIN; CRC sampled in HDR (one cycle after eop word), includes last word.
REQ-018 DRAIN: one payload word per cycle in arrival order while q_full[dest]=0; q_wr_en=0 while full; after last word -> IDLE.
REQ-019 q_wr_sel = dest throughout HDR and DRAIN; q_wr_en=0, q_wr_data=0 in other states.
REQ-020 Latency: header write earliest 1 cycle after eop word accepted; in_ready=1 cycle after final payload write.
REQ-021 Overflow: payload word accepted when count = BUF_DEPTH or count = 2^DATABUF_HIGH_NUM-1 -> DROP; DROP discards to wr_eop, then IDLE with drop pulse.
REQ-022 wr_sop & wr_eop same word (zero payload) -> dropped, drop pulse, stay IDLE.
REQ-023 wr_sop during RECV: current frame dropped (drop pulse), new descriptor accepted, RECV restarts.
REQ-024 wr_sop during DROP: ends DROP, new frame accepted as in REQ-014.
REQ-025 busy=1 in RECV, HDR, DRAIN, DROP.

Reset
REQ-026 Reset SHALL force IDLE; in_ready=0 during reset, 1 first cycle after.
REQ-027 Reset SHALL clear q_wr_en, q_wr_sel, q_wr_data, busy, drop, counters, CRC, frame_drop_cnt.
REQ-028 Reset mid-RECV/HDR/DRAIN SHALL abandon the frame with no further queue writes, no drop pulse.

Configuration
REQ-029 Macro FRAME_DROP_CNT_EN defined: adds output frame_drop_cnt (16 bits), +1 per drop pulse, saturating at 65535.
REQ-030 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 Desc pri=5 dest=3, payload 0x11,0x22,0x33, q_full=0 -> header count=3, CRC=crc16_32bit over three words, pri=5 on q_wr_sel=3, then 0x11,0x22,0x33 on consecutive cycles.
REQ-032 As REQ-031 with q_full[3]=1 for 4 cycles at first DRAIN word -> q_wr_en=0 those 4 cycles, order preserved, no loss.
REQ-033 65 payload words, BUF_DEPTH=64 -> no queue writes, one drop pulse at eop, frame_drop_cnt=1 with FRAME_DROP_CNT_EN.
REQ-034 Descriptor with sop&eop together -> drop pulse, in_ready stays 1, no writes.
REQ-035 wr_sop after 2 payload words of frame A (dest 1), then frame B dest 7 with 1 word -> one drop, only B written to queue 7 with count=1.
REQ-036 Reset asserted after header written, 2 of 5 payload words drained -> no writes after reset, in_ready=1 cycle after release.
